frog_carrier: RTL and testbench
===============================

# frog_carrier

Frog position controller on the receiving end of the pad collision/motion interface. Each frame it takes hop commands, the per-pad `Collision` flags and the per-pad `MotionX` values, and does three things: moves the frog by hops, carries the frog along with whichever pad it sits on, and declares death when the frog is in the river with no pad under it. It sits between the keyboard decoder and the frog sprite/score logic. Every lilypad/log instance feeds it.

## Interface
Parameters:
- `NUM_PADS`, 4: number of pad instances on the collision/motion buses.
- `FROG_STEP`, 11'd40: hop distance in pixels.
- `X_MAX`, 11'd600: largest legal `Frog_X` (640 minus the frog side).
- `Y_MAX`, 11'd440: largest legal `Frog_Y`.
- `RIVER_Y_MIN`, 11'd80: top row of the river band, inclusive.
- `RIVER_Y_MAX`, 11'd240: bottom boundary of the river band, exclusive.
- `HOME_Y`, 11'd40: a frog at or above this row is home.
- `HOP_LOCK`, 3: frames during which hops are ignored after a hop.
- `DEAD_FRAMES`, 11'd60: frames spent dead before respawn.

Ports:
- `frame_clk`, in, 1: single clock, one edge per video frame.
- `Reset`, in, 1: synchronous, active-high.
- `Frog_Start_X`, `Frog_Start_Y`, in, 11 each: respawn position.
- `Hop_Valid`, in, 1: one-frame hop request.
- `Hop_Dir`, in, 2: 0 up, 1 down, 2 left, 3 right.
- `Pad_Collision`, in, `NUM_PADS`: bit i is pad i's collision flag.
- `Pad_MotionX`, in, `NUM_PADS*11`: pad i's motion in bits [11i+10:11i], 11-bit two's complement.
- `Frog_X`, `Frog_Y`, out, 11 each: frog position.
- `Frog_Dead`, out, 1: high while in DEAD.
- `Frog_Home`, out, 1: high while in HOME.
- `Riding`, out, 1: a pad was selected this frame.
- `Lives`, out, 2: remaining lives.

## Operation
States:
- ALIVE
- LOCK: hop cooldown. Riding and the drown check stay active.
- DEAD
- HOME

Reset:
- All outputs take their reset values on the first edge with `Reset` high.
- State becomes ALIVE.
- `Frog_X`/`Frog_Y` are loaded from `Frog_Start_X`/`Frog_Start_Y`.
- `Lives`=3, `Frog_Dead`=0, `Frog_Home`=0, `Riding`=0, all counters 0.
- `Reset` overrides everything, including a DEAD or HOME countdown in progress.

Pad selection:
- The selected pad is the lowest-index set bit of `Pad_Collision`.
- `Riding` = |`Pad_Collision` AND the frog is in the river band.

Per frame in ALIVE or LOCK, in priority order:
1. Drown: the frog is in the river band and `Riding`=0 → DEAD. No hop and no carry is applied that frame.
2. Hop: `Hop_Valid` in ALIVE → position ± `FROG_STEP` in direction `Hop_Dir`, then LOCK with counter=`HOP_LOCK`.
   - A hop that would leave [0, `X_MAX`] or [0, `Y_MAX`] is dropped. LOCK is still entered.
   - `Hop_Valid` in LOCK is ignored, not queued.
3. Carry: if `Riding`, `Frog_X` += selected pad's `MotionX`, computed at 12 bits.
   - Result < 0 or > `X_MAX` → DEAD (carried off-screen).
   - Carry is not applied on a frame where a hop is applied.

LOCK countdown:
- The counter decrements each frame.
- At 1, the state returns to ALIVE.

HOME:
- ALIVE/LOCK with `Frog_Y` ≤ `HOME_Y` after the update → HOME.
- HOME holds `DEAD_FRAMES` frames, then respawns. `Lives` is unchanged.

DEAD:
- On entry: `Lives` decrements, saturating at 0, and the counter loads `DEAD_FRAMES`.
- Position is frozen.
- When the counter reaches 1: if `Lives`≠0, respawn to the start position and go to ALIVE; if `Lives`=0, stay in DEAD permanently (game over until `Reset`).

## Timing
- Registered outputs. All effects are visible on the edge after the inputs are sampled.
- A hop moves `Frog_X`/`Frog_Y` one frame after `Hop_Valid`.
- Collision uses the previous frame's frog position; one frame of skew is accepted.
- Pads emit `MotionX`=0 on wait frames, so the carry is a no-op on those frames.
- Simultaneous collisions with several pads: the lowest index wins.
- Entering the river band and drowning: the drown check on the edge after a hop uses the post-hop position. A pad already under the frog saves it.

## Structure
- Package `frogger_pkg`:
  - `frog_state_t` enum (ALIVE, LOCK, DEAD, HOME).
  - `hop_dir_t` enum.
  - Screen constants 640/480 and `FROG_SIDE`=40.
- Sub-module `pad_select`: combinational priority encoder. Outputs the index, the any-hit flag and the muxed `MotionX`.

## Test plan
- Reset with start (320,440) → `Frog_X`=320, `Frog_Y`=440, `Lives`=3. `Hop_Valid`, `Hop_Dir`=0 → `Frog_Y`=400 next frame. A second hop 1 frame later is ignored; after 3 frames a hop to 360 is accepted.
- `Frog_X`=0, hop left → position unchanged, state LOCK.
- Frog at `Frog_Y`=200, `Pad_Collision`=4'b0110, pad1 `MotionX`=11'h7D8 (−40), pad2 +40 → `Frog_X` decreases by 40 (pad1 wins), `Riding`=1.
- Frog at y=200, `Pad_Collision`=0 → `Frog_Dead`=1 next frame, `Lives` 3→2. Respawn to start after 60 frames.
- Riding at `Frog_X`=20 with `MotionX`=−40 → DEAD (off-screen). With `Lives`=1 → stays DEAD beyond 60 frames. `Reset` mid-count → ALIVE, `Lives`=3.
- Hop up from y=80 → y=40, `Frog_Home`=1 for 60 frames, then respawn; `Lives` unchanged.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and screen geometry for the frogger playfield blocks.
package frogger_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned FROG_SIDE = 40;
  localparam int unsigned COORD_W   = 11;

  typedef enum logic [1:0] {
    ALIVE,
    LOCK,
    DEAD,
    HOME
  } frog_state_t;

  typedef enum logic [1:0] {
    HOP_UP,
    HOP_DOWN,
    HOP_LEFT,
    HOP_RIGHT
  } hop_dir_t;

endpackage

// File: rtl/pad_select.sv
// Priority encoder over the pad collision bus: lowest-index hit wins and its motion is muxed out.
module pad_select
  import frogger_pkg::*;
#(
  parameter int unsigned NUM_PADS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic [NUM_PADS-1:0]         collision,
  input  logic [NUM_PADS*COORD_W-1:0] motion_x,
  output logic [IDX_W-1:0]            sel_idx_c,
  output logic                        hit_c,
  output logic [COORD_W-1:0]          motion_x_c
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    sel_idx_c  = '0;
    hit_c      = 1'b0;
    motion_x_c = '0;
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (collision[i]) begin
        sel_idx_c  = IDX_W'(i);
        hit_c      = 1'b1;
        motion_x_c = motion_x[i*COORD_W +: COORD_W];
      end
    end
  end

endmodule

// File: rtl/frog_carrier.sv
// Frog position controller: hops, rides pads, drowns or falls off-screen, and handles home/respawn.
module frog_carrier
  import frogger_pkg::*;
#(
  parameter int unsigned NUM_PADS    = 4,
  parameter logic [10:0] FROG_STEP   = 11'd40,
  parameter logic [10:0] X_MAX       = 11'd600,
  parameter logic [10:0] Y_MAX       = 11'd440,
  parameter logic [10:0] RIVER_Y_MIN = 11'd80,
  parameter logic [10:0] RIVER_Y_MAX = 11'd240,
  parameter logic [10:0] HOME_Y      = 11'd40,
  parameter int unsigned HOP_LOCK    = 3,
  parameter logic [10:0] DEAD_FRAMES = 11'd60
) (
  input  logic                        frame_clk,
  input  logic                        Reset,
  input  logic [10:0]                 Frog_Start_X,
  input  logic [10:0]                 Frog_Start_Y,
  input  logic                        Hop_Valid,
  input  logic [1:0]                  Hop_Dir,
  input  logic [NUM_PADS-1:0]         Pad_Collision,
  input  logic [NUM_PADS*COORD_W-1:0] Pad_MotionX,
  output logic [10:0]                 Frog_X,
  output logic [10:0]                 Frog_Y,
  output logic                        Frog_Dead,
  output logic                        Frog_Home,
  output logic                        Riding,
  output logic [1:0]                  Lives
);

  localparam int unsigned IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  frog_state_t        state;
  logic [10:0]        cnt;

  logic [IDX_W-1:0]   pad_idx_unused;
  logic               pad_hit_c;
  logic [COORD_W-1:0] pad_motion_c;

  logic               in_river_c;
  logic               riding_c;
  logic               hop_req_c;
  logic               hop_ok_c;
  logic               hop_apply_c;
  logic [10:0]        hop_x_c;
  logic [10:0]        hop_y_c;
  logic [COORD_W:0]   carry_sum_c;
  logic               carry_off_c;
  logic               drown_c;
  logic [10:0]        next_x_c;
  logic [10:0]        next_y_c;
  logic [1:0]         lives_dec_c;

  pad_select #(
    .NUM_PADS (NUM_PADS),
    .IDX_W    (IDX_W)
  ) u_pad_select (
    .collision  (Pad_Collision),
    .motion_x   (Pad_MotionX),
    .sel_idx_c  (pad_idx_unused),
    .hit_c      (pad_hit_c),
    .motion_x_c (pad_motion_c)
  );

  assign in_river_c  = (Frog_Y >= RIVER_Y_MIN) && (Frog_Y < RIVER_Y_MAX);
  assign riding_c    = pad_hit_c && in_river_c;
  assign drown_c     = in_river_c && !riding_c;
  assign hop_req_c   = Hop_Valid && (state == ALIVE);
  assign hop_apply_c = hop_req_c && hop_ok_c;
  assign lives_dec_c = (Lives == 2'd0) ? 2'd0 : Lives - 2'd1;

  // Signed 12-bit carry so a negative result is visible in the top bit.
  assign carry_sum_c = {1'b0, Frog_X} + {pad_motion_c[COORD_W-1], pad_motion_c};
  assign carry_off_c = riding_c && !hop_apply_c &&
                       (carry_sum_c[COORD_W] || (carry_sum_c[COORD_W-1:0] > X_MAX));

  // Candidate hop target; out-of-range hops leave hop_ok_c low.
  always_comb begin
    hop_x_c  = Frog_X;
    hop_y_c  = Frog_Y;
    hop_ok_c = 1'b0;
    case (hop_dir_t'(Hop_Dir))
      HOP_UP: begin
        if (Frog_Y >= FROG_STEP) begin
          hop_y_c  = Frog_Y - FROG_STEP;
          hop_ok_c = 1'b1;
        end
      end
      HOP_DOWN: begin
        if (({1'b0, Frog_Y} + {1'b0, FROG_STEP}) <= {1'b0, Y_MAX}) begin
          hop_y_c  = Frog_Y + FROG_STEP;
          hop_ok_c = 1'b1;
        end
      end
      HOP_LEFT: begin
        if (Frog_X >= FROG_STEP) begin
          hop_x_c  = Frog_X - FROG_STEP;
          hop_ok_c = 1'b1;
        end
      end
      HOP_RIGHT: begin
        if (({1'b0, Frog_X} + {1'b0, FROG_STEP}) <= {1'b0, X_MAX}) begin
          hop_x_c  = Frog_X + FROG_STEP;
          hop_ok_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    next_x_c = Frog_X;
    next_y_c = Frog_Y;
    if (hop_apply_c) begin
      next_x_c = hop_x_c;
      next_y_c = hop_y_c;
    end else if (riding_c) begin
      next_x_c = carry_sum_c[COORD_W-1:0];
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state     <= ALIVE;
      cnt       <= '0;
      Frog_X    <= Frog_Start_X;
      Frog_Y    <= Frog_Start_Y;
      Frog_Dead <= 1'b0;
      Frog_Home <= 1'b0;
      Riding    <= 1'b0;
      Lives     <= 2'd3;
    end else begin
      case (state)
        ALIVE, LOCK: begin
          Riding <= riding_c;
          if (drown_c || carry_off_c) begin
            state     <= DEAD;
            Frog_Dead <= 1'b1;
            Lives     <= lives_dec_c;
            cnt       <= DEAD_FRAMES;
          end else begin
            Frog_X <= next_x_c;
            Frog_Y <= next_y_c;
            if (next_y_c <= HOME_Y) begin
              state     <= HOME;
              Frog_Home <= 1'b1;
              cnt       <= DEAD_FRAMES;
            end else if (hop_req_c) begin
              state <= LOCK;
              cnt   <= 11'(HOP_LOCK);
            end else if (state == LOCK) begin
              cnt <= cnt - 11'd1;
              if (cnt == 11'd1) state <= ALIVE;
            end
          end
        end
        DEAD: begin
          Riding <= 1'b0;
          // With no lives left the countdown parks at 1 until Reset.
          if (cnt == 11'd1) begin
            if (Lives != 2'd0) begin
              state     <= ALIVE;
              cnt       <= '0;
              Frog_X    <= Frog_Start_X;
              Frog_Y    <= Frog_Start_Y;
              Frog_Dead <= 1'b0;
            end
          end else begin
            cnt <= cnt - 11'd1;
          end
        end
        HOME: begin
          Riding <= 1'b0;
          if (cnt == 11'd1) begin
            state     <= ALIVE;
            cnt       <= '0;
            Frog_X    <= Frog_Start_X;
            Frog_Y    <= Frog_Start_Y;
            Frog_Home <= 1'b0;
          end else begin
            cnt <= cnt - 11'd1;
          end
        end
        default: state <= ALIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_frog_carrier.sv
// Scoreboard bench for frog_carrier: expected frames queued with stimulus, compared per scenario.
module tb_frog_carrier;
  import frogger_pkg::*;

  localparam logic [10:0] M_N40 = 11'h7D8;
  localparam logic [10:0] M_P40 = 11'd40;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        dead;
    logic        home;
    logic        riding;
    logic [1:0]  lives;
  } obs_t;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [10:0] Frog_Start_X = 11'd320;
  logic [10:0] Frog_Start_Y = 11'd440;
  logic        Hop_Valid = 1'b0;
  logic [1:0]  Hop_Dir = 2'd0;
  logic [3:0]  Pad_Collision = 4'd0;
  logic [43:0] Pad_MotionX = '0;
  logic [10:0] Frog_X;
  logic [10:0] Frog_Y;
  logic        Frog_Dead;
  logic        Frog_Home;
  logic        Riding;
  logic [1:0]  Lives;

  obs_t  exp_q[$];
  obs_t  obs_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  frog_carrier dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .Frog_Start_X  (Frog_Start_X),
    .Frog_Start_Y  (Frog_Start_Y),
    .Hop_Valid     (Hop_Valid),
    .Hop_Dir       (Hop_Dir),
    .Pad_Collision (Pad_Collision),
    .Pad_MotionX   (Pad_MotionX),
    .Frog_X        (Frog_X),
    .Frog_Y        (Frog_Y),
    .Frog_Dead     (Frog_Dead),
    .Frog_Home     (Frog_Home),
    .Riding        (Riding),
    .Lives         (Lives)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic obs_t mk(input int x, input int y, input int dead, input int home,
                              input int riding, input int lives);
    obs_t o;
    o.x      = 11'(x);
    o.y      = 11'(y);
    o.dead   = 1'(dead);
    o.home   = 1'(home);
    o.riding = 1'(riding);
    o.lives  = 2'(lives);
    return o;
  endfunction

  // Drive one frame's inputs, run reps edges, then optionally queue expected and captured outputs.
  task automatic drive(input logic rst, input logic hv, input logic [1:0] dir,
                       input logic [3:0] coll, input logic [43:0] mx, input int reps,
                       input logic chk, input obs_t e, input string nm);
    Reset         = rst;
    Hop_Valid     = hv;
    Hop_Dir       = dir;
    Pad_Collision = coll;
    Pad_MotionX   = mx;
    for (int k = 0; k < reps; k++) begin
      @(posedge frame_clk);
      #1;
      Reset     = 1'b0;
      Hop_Valid = 1'b0;
    end
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
      obs_q.push_back({Frog_X, Frog_Y, Frog_Dead, Frog_Home, Riding, Lives});
    end
  endtask

  task automatic test_reset();
    obs_t e, o;
    string nm;
    Frog_Start_X = 11'd320;
    Frog_Start_Y = 11'd440;
    drive(1, 0, 2'd0, 4'd0, '0, 1, 1, mk(320, 440, 0, 0, 0, 3), "reset_state");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d, want x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d",
                 nm, o.x, o.y, o.dead, o.home, o.riding, o.lives, e.x, e.y, e.dead, e.home, e.riding, e.lives);
      end
    end
  endtask

  task automatic test_hop_lock();
    obs_t e, o;
    string nm;
    drive(0, 1, HOP_UP, 4'd0, '0, 1, 1, mk(320, 400, 0, 0, 0, 3), "hop_up");
    drive(0, 1, HOP_UP, 4'd0, '0, 1, 1, mk(320, 400, 0, 0, 0, 3), "hop_in_lock_ignored");
    drive(0, 0, HOP_UP, 4'd0, '0, 1, 0, '0, "");
    drive(0, 1, HOP_UP, 4'd0, '0, 1, 1, mk(320, 400, 0, 0, 0, 3), "hop_last_lock_frame");
    drive(0, 1, HOP_UP, 4'd0, '0, 1, 1, mk(320, 360, 0, 0, 0, 3), "hop_after_lock");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d, want x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d",
                 nm, o.x, o.y, o.dead, o.home, o.riding, o.lives, e.x, e.y, e.dead, e.home, e.riding, e.lives);
      end
    end
  endtask

  task automatic test_hop_bounds();
    obs_t e, o;
    string nm;
    Frog_Start_X = 11'd0;
    Frog_Start_Y = 11'd440;
    drive(1, 0, 2'd0, 4'd0, '0, 1, 0, '0, "");
    drive(0, 1, HOP_LEFT, 4'd0, '0, 1, 1, mk(0, 440, 0, 0, 0, 3), "hop_left_at_x0");
    drive(0, 1, HOP_RIGHT, 4'd0, '0, 1, 1, mk(0, 440, 0, 0, 0, 3), "lock_after_dropped_hop");
    drive(0, 0, 2'd0, 4'd0, '0, 2, 0, '0, "");
    drive(0, 1, HOP_DOWN, 4'd0, '0, 1, 1, mk(0, 440, 0, 0, 0, 3), "hop_down_at_ymax");
    drive(0, 0, 2'd0, 4'd0, '0, 3, 0, '0, "");
    drive(0, 1, HOP_RIGHT, 4'd0, '0, 1, 1, mk(40, 440, 0, 0, 0, 3), "hop_right");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d, want x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d",
                 nm, o.x, o.y, o.dead, o.home, o.riding, o.lives, e.x, e.y, e.dead, e.home, e.riding, e.lives);
      end
    end
  endtask

  task automatic test_carry();
    obs_t e, o;
    string nm;
    logic [43:0] mx, mx_wait;
    mx      = {11'd7, M_P40, M_N40, 11'd5};
    mx_wait = {11'd7, 11'd0, M_N40, 11'd5};
    Frog_Start_X = 11'd320;
    Frog_Start_Y = 11'd200;
    drive(1, 0, 2'd0, 4'b0110, mx, 1, 1, mk(320, 200, 0, 0, 0, 3), "reset_on_pad");
    drive(0, 0, 2'd0, 4'b0110, mx, 1, 1, mk(280, 200, 0, 0, 1, 3), "carry_lowest_pad");
    drive(0, 0, 2'd0, 4'b0100, mx, 1, 1, mk(320, 200, 0, 0, 1, 3), "carry_pad2");
    drive(0, 0, 2'd0, 4'b0100, mx_wait, 1, 1, mk(320, 200, 0, 0, 1, 3), "carry_wait_frame");
    drive(0, 1, HOP_UP, 4'b0100, mx, 1, 1, mk(320, 160, 0, 0, 1, 3), "hop_suppresses_carry");
    drive(0, 0, 2'd0, 4'b0100, mx, 1, 1, mk(360, 160, 0, 0, 1, 3), "carry_during_lock");
    drive(0, 0, 2'd0, 4'b0100, mx, 6, 1, mk(600, 160, 0, 0, 1, 3), "carry_to_xmax");
    drive(0, 0, 2'd0, 4'b0100, mx, 1, 1, mk(600, 160, 1, 0, 1, 2), "carry_past_xmax");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d, want x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d",
                 nm, o.x, o.y, o.dead, o.home, o.riding, o.lives, e.x, e.y, e.dead, e.home, e.riding, e.lives);
      end
    end
  endtask

  task automatic test_drown();
    obs_t e, o;
    string nm;
    Frog_Start_X = 11'd320;
    Frog_Start_Y = 11'd200;
    drive(1, 0, 2'd0, 4'd0, '0, 1, 0, '0, "");
    drive(0, 0, 2'd0, 4'd0, '0, 1, 1, mk(320, 200, 1, 0, 0, 2), "drown");
    drive(0, 0, 2'd0, 4'd0, '0, 59, 1, mk(320, 200, 1, 0, 0, 2), "dead_last_frame");
    drive(0, 0, 2'd0, 4'd0, '0, 1, 1, mk(320, 200, 0, 0, 0, 2), "respawn");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d, want x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d",
                 nm, o.x, o.y, o.dead, o.home, o.riding, o.lives, e.x, e.y, e.dead, e.home, e.riding, e.lives);
      end
    end
  endtask

  task automatic test_game_over();
    obs_t e, o;
    string nm;
    logic [43:0] mx;
    mx = {11'd0, 11'd0, 11'd0, M_N40};
    Frog_Start_X = 11'd20;
    Frog_Start_Y = 11'd200;
    drive(1, 0, 2'd0, 4'b0001, mx, 1, 0, '0, "");
    drive(0, 0, 2'd0, 4'b0001, mx, 1, 1, mk(20, 200, 1, 0, 1, 2), "carried_offscreen");
    drive(0, 0, 2'd0, 4'b0001, mx, 61, 1, mk(20, 200, 1, 0, 1, 1), "second_death");
    drive(0, 0, 2'd0, 4'b0001, mx, 61, 1, mk(20, 200, 1, 0, 1, 0), "third_death");
    drive(0, 0, 2'd0, 4'b0001, mx, 100, 1, mk(20, 200, 1, 0, 0, 0), "game_over_hold");
    drive(1, 0, 2'd0, 4'b0001, mx, 1, 1, mk(20, 200, 0, 0, 0, 3), "reset_after_game_over");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d, want x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d",
                 nm, o.x, o.y, o.dead, o.home, o.riding, o.lives, e.x, e.y, e.dead, e.home, e.riding, e.lives);
      end
    end
  endtask

  task automatic test_home();
    obs_t e, o;
    string nm;
    Frog_Start_X = 11'd320;
    Frog_Start_Y = 11'd80;
    drive(1, 0, 2'd0, 4'b0001, '0, 1, 0, '0, "");
    drive(0, 1, HOP_UP, 4'b0001, '0, 1, 1, mk(320, 40, 0, 1, 1, 3), "hop_home");
    drive(0, 0, 2'd0, 4'b0001, '0, 59, 1, mk(320, 40, 0, 1, 0, 3), "home_last_frame");
    drive(0, 0, 2'd0, 4'b0001, '0, 1, 1, mk(320, 80, 0, 0, 0, 3), "home_respawn");
    drive(0, 1, HOP_UP, 4'b0001, '0, 1, 0, '0, "");
    drive(0, 0, 2'd0, 4'b0001, '0, 20, 1, mk(320, 40, 0, 1, 0, 3), "home_mid_count");
    drive(1, 0, 2'd0, 4'b0001, '0, 1, 1, mk(320, 80, 0, 0, 0, 3), "reset_mid_home");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d, want x=%0d y=%0d dead=%0b home=%0b riding=%0b lives=%0d",
                 nm, o.x, o.y, o.dead, o.home, o.riding, o.lives, e.x, e.y, e.dead, e.home, e.riding, e.lives);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_hop_lock();
    test_hop_bounds();
    test_carry();
    test_drown();
    test_game_over();
    test_home();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
